// File: rtl/segment_pkg.sv
// -----------------------------------------------------------------------------
// segment_pkg
// Shared constants for the dual-digit seven-segment encoder.
//   SEG_W        width of one segment word (DIG, DP, g..a)
//   SEG_BLANK    digit common off, all segments off, DP off
//   SEG_0..SEG_9 lit-segment patterns for the decimal digits
//   CODE_BLANK   first input code that is displayed as blank (10..15)
// Segment word: bit 8 = DIG (active low), bit 7 = DP (always 0),
// bits 6:0 = g,f,e,d,c,b,a (active high).
// -----------------------------------------------------------------------------
package segment_pkg;

   localparam int unsigned SEG_W = 9;

   localparam logic [SEG_W-1:0] SEG_BLANK = 9'h100;

   localparam logic [SEG_W-1:0] SEG_0 = 9'h03F;
   localparam logic [SEG_W-1:0] SEG_1 = 9'h006;
   localparam logic [SEG_W-1:0] SEG_2 = 9'h05B;
   localparam logic [SEG_W-1:0] SEG_3 = 9'h04F;
   localparam logic [SEG_W-1:0] SEG_4 = 9'h066;
   localparam logic [SEG_W-1:0] SEG_5 = 9'h06D;
   localparam logic [SEG_W-1:0] SEG_6 = 9'h07D;
   localparam logic [SEG_W-1:0] SEG_7 = 9'h007;
   localparam logic [SEG_W-1:0] SEG_8 = 9'h07F;
   localparam logic [SEG_W-1:0] SEG_9 = 9'h06F;

   localparam logic [3:0] CODE_BLANK = 4'd10;

endpackage : segment_pkg

// File: rtl/seg7_digit_lut.sv
// -----------------------------------------------------------------------------
// seg7_digit_lut
// Purely combinational code-to-segment-word lookup for one digit.
// Ports:
//   code_i  [3:0]        digit code, 0..9 digits, 10..15 blank
//   seg_o   [SEG_W-1:0]  segment word (DIG enabled for 0..9)
// -----------------------------------------------------------------------------
module seg7_digit_lut
   import segment_pkg::*;
(
   input  logic [3:0]       code_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (code_i < CODE_BLANK) begin
         unique case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule : seg7_digit_lut

// File: rtl/segment_encoder.sv
// -----------------------------------------------------------------------------
// segment_encoder
// Dual-digit BCD-to-seven-segment encoder with registered outputs.
// Each output reflects its digit code sampled one rising edge earlier.
// Ports:
//   clk     system clock, all state on rising edge
//   rst     synchronous active-high reset, loads blank into both outputs
//   data_1  [3:0] digit code for display 1 (10..15 = blank)
//   data_2  [3:0] digit code for display 2 (10..15 = blank)
//   seg_1   [8:0] segment word for display 1
//   seg_2   [8:0] segment word for display 2
// Optional feature macro: SEGMENT_ENCODER_LZ_BLANK_EN
//   When defined, display 1 is treated as the tens digit and a 0 on it is
//   shown blank (leading-zero blanking). Display 2 is never affected.
// -----------------------------------------------------------------------------
module segment_encoder
   import segment_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       data_1,
   input  logic [3:0]       data_2,
   output logic [SEG_W-1:0] seg_1,
   output logic [SEG_W-1:0] seg_2
);

   logic [SEG_W-1:0] lut_1;
   logic [SEG_W-1:0] lut_2;
   logic [SEG_W-1:0] seg_1_d, seg_1_q;
   logic [SEG_W-1:0] seg_2_d, seg_2_q;

   seg7_digit_lut u_lut_1 (
      .code_i (data_1),
      .seg_o  (lut_1)
   );

   seg7_digit_lut u_lut_2 (
      .code_i (data_2),
      .seg_o  (lut_2)
   );

   always_comb begin
      seg_2_d = lut_2;
`ifdef SEGMENT_ENCODER_LZ_BLANK_EN
      // Tens digit: suppress a leading zero regardless of the units digit.
      seg_1_d = (data_1 == 4'd0) ? SEG_BLANK : lut_1;
`else
      seg_1_d = lut_1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_1_q <= SEG_BLANK;
         seg_2_q <= SEG_BLANK;
      end else begin
         seg_1_q <= seg_1_d;
         seg_2_q <= seg_2_d;
      end
   end

   // Direct register outputs keep the display pins glitch-free.
   assign seg_1 = seg_1_q;
   assign seg_2 = seg_2_q;

endmodule : segment_encoder

// File: tb/tb_segment_encoder.sv
// -----------------------------------------------------------------------------
// tb_segment_encoder
// Scoreboard bench: the driver pushes the expected {seg_1, seg_2} for every
// cycle it drives; the monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_segment_encoder;

   logic       clk;
   logic       rst;
   logic [3:0] data_1;
   logic [3:0] data_2;
   logic [8:0] seg_1;
   logic [8:0] seg_2;

   int unsigned n_checks;
   int unsigned n_errors;

   logic [17:0] exp_q[$];

   segment_encoder dut (
      .clk    (clk),
      .rst    (rst),
      .data_1 (data_1),
      .data_2 (data_2),
      .seg_1  (seg_1),
      .seg_2  (seg_2)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // Segment letters lit per decimal digit (a..g), built into the word
   // bit by bit: a = bit 0 ... g = bit 6; DIG active low at bit 8.
   function automatic logic [8:0] ref_digit(input int code);
      string lit;
      logic [8:0] w;
      case (code)
         0: lit = "abcdef";
         1: lit = "bc";
         2: lit = "abdeg";
         3: lit = "abcdg";
         4: lit = "bcfg";
         5: lit = "acdfg";
         6: lit = "acdefg";
         7: lit = "abc";
         8: lit = "abcdefg";
         9: lit = "abcdfg";
         default: lit = "";
      endcase
      if (lit.len() == 0) return 9'h100;
      w = 9'h000;
      for (int i = 0; i < lit.len(); i++) w[lit[i] - "a"] = 1'b1;
      return w;
   endfunction

   function automatic logic [17:0] ref_pair(input logic r, input int d1, input int d2);
      logic [8:0] s1;
      logic [8:0] s2;
      if (r) return {9'h100, 9'h100};
      s1 = ref_digit(d1);
      s2 = ref_digit(d2);
`ifdef SEGMENT_ENCODER_LZ_BLANK_EN
      if (d1 == 0) s1 = 9'h100;
`endif
      return {s1, s2};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic r, input int d1, input int d2);
      @(negedge clk);
      rst    = r;
      data_1 = d1[3:0];
      data_2 = d2[3:0];
      exp_q.push_back(ref_pair(r, d1, d2));
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [17:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({seg_1, seg_2} !== e) begin
               n_errors++;
               $display("FAIL seg_pair t=%0t actual seg_1=%03h seg_2=%03h required seg_1=%03h seg_2=%03h",
                        $time, seg_1, seg_2, e[17:9], e[8:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      data_1   = 4'd0;
      data_2   = 4'd0;

      // Reset held 3 cycles with live data, then release.
      repeat (3) drive(1'b1, 5, 7);
      drive(1'b0, 5, 7);

      // Full sweep with wrap.
      for (int i = 0; i < 21; i++) drive(1'b0, i % 11, (i + 1) % 11);

      // Codes 11..15 on both digits.
      for (int c = 11; c <= 15; c++) drive(1'b0, c, 26 - c);

      // Latency step on digit 2.
      drive(1'b0, 1, 3);
      drive(1'b0, 1, 8);

      // Sweep with a one-cycle mid-stream reset.
      for (int i = 0; i < 12; i++) drive(i == 6, i % 11, (i + 4) % 11);

      // Leading zero case.
      drive(1'b0, 0, 0);
      drive(1'b0, 0, 9);

      // Randomised traffic with occasional reset.
      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 15), $urandom_range(0, 15));

      // Drain: bounded wait for the monitor to consume the queue.
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_segment_encoder

// File: doc/segment_encoder.md
# segment_encoder

Dual-digit BCD-to-seven-segment encoder for the reaction-time tester display. Converts two 4-bit digit codes (`data_1`, `data_2`) into two 9-bit segment words (`seg_1`, `seg_2`) that drive the two on-board digits. The outputs are registered. It sits between the timing/score logic and the display pins.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk`  input  1  system clock, 100 MHz nominal, all state on rising edge
- `rst`  input  1  reset, synchronous and active-high
- `data_1`  input  4  digit code for display 1; 0–9 are digits, 10–15 mean blank
- `data_2`  input  4  digit code for display 2; same coding as `data_1`
- `seg_1`  output  9  segment word for display 1
- `seg_2`  output  9  segment word for display 2

Segment word layout (both outputs):
- bit 8: DIG, the active-low digit common. 0 = digit on, 1 = digit off.
- bit 7: DP. Always 0.
- bits 6:0: segments g,f,e,d,c,b,a, active-high. 1 = segment lit.

## Operation
- Each digit is encoded independently with an identical mapping.
- Code mapping (9-bit hex):
  - 0 → 03F
  - 1 → 006
  - 2 → 05B
  - 3 → 04F
  - 4 → 066
  - 5 → 06D
  - 6 → 07D
  - 7 → 007
  - 8 → 07F
  - 9 → 06F
- Codes 10–15 → 100 (blank): DIG off, all segments off, DP off.
- DP is never lit. No other input affects the output.
- No state beyond the output registers. No FSM.

## Timing
- Latency is 1 clock: `seg_n` at edge k+1 reflects `data_n` sampled at edge k.
- Throughput is one new code per cycle per digit. A new value can appear on every edge.
- Reset: while `rst` is high at a rising edge, both outputs load 100 (blank). `rst` takes priority over data.
- Release: the first edge with `rst` low loads the encoded current inputs.
- Reset asserted mid-stream blanks both outputs on the next edge. No partial update.
- `data_1` and `data_2` changing on the same edge update both outputs on the same following edge.
- Code wrap 10→0 is handled with no special case: blank, then 03F.
- Outputs are glitch-free (direct register outputs).

## Configuration
- Macro: `SEGMENT_ENCODER_LZ_BLANK_EN` (leading-zero blanking).
- Defined:
  - `data_1` is the tens digit.
  - When `data_1` is 0, `seg_1` shows blank (100) instead of 03F, regardless of `data_2`.
  - `seg_2` is unaffected, so 0 still shows as 03F on display 2.
  - Latency and reset behaviour are unchanged.
- Not defined: straight mapping as in Operation, so 0 on display 1 shows 03F.

## Structure
- Shared package `segment_pkg`:
  - segment-word width constant (9)
  - `SEG_BLANK` = 9'h100
  - the ten digit pattern constants
  - `CODE_BLANK` = 4'd10
- Sub-module `seg7_digit_lut`: combinational 4-bit code → 9-bit word, instantiated twice.
- The top level holds the two output registers, the reset, and the optional leading-zero override on digit 1.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `data_1`=5, `data_2`=7 → `seg_1` = `seg_2` = 100 throughout. First edge after release → `seg_1`=06D, `seg_2`=007.
- Full sweep: `data_1` counts 0..10 and wraps, `data_2` counts 1..10,0,… each cycle for 21 cycles. Each output equals the mapping of the previous cycle's input. Code 10 gives 100; after wrap, 0 gives 03F.
- Codes 11–15 on both inputs → 100 on each, one cycle later.
- Latency: step `data_2` 3→8 at one edge → `seg_2` is 04F for that cycle, then 07F at the next edge.
- Mid-stream reset: assert `rst` for one cycle during the sweep → both outputs 100 on that edge, then normal mapping resumes with no stale value.
- Leading zero, macro defined: `data_1`=0, `data_2`=0 → `seg_1`=100, `seg_2`=03F. Macro undefined, same inputs → both 03F.
